// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle main-control sequencer: opcodes,
// FSM states, instruction classes and the per-class datapath controls.
package ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_VECTOR = 7'b1010111;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_VEC, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
    } imm_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00, ALU_BRANCH = 2'b01, ALU_OP = 2'b10, ALU_OP_IMM = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        FAULT_NONE = 2'b00, FAULT_ILLEGAL = 2'b01, FAULT_TIMEOUT = 2'b10
    } fault_code_t;

    typedef enum logic [3:0] {
        CLS_OP, CLS_OP_IMM, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_LUI,
        CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_VECTOR, CLS_ILLEGAL
    } instr_class_t;

    // Datapath controls that stay constant from EXEC until the instruction retires.
    typedef struct packed {
        alu_op_t  alu_op;
        logic     alu_src;
        imm_sel_t imm_sel;
        logic     mem_to_reg;
    } class_ctrl_t;

    function automatic class_ctrl_t class_ctrl(input instr_class_t cls);
        class_ctrl_t c;
        c.alu_op     = ALU_ADD;
        c.alu_src    = 1'b0;
        c.imm_sel    = IMM_I;
        c.mem_to_reg = 1'b0;
        case (cls)
            CLS_OP:     c.alu_op = ALU_OP;
            CLS_OP_IMM: begin c.alu_op = ALU_OP_IMM; c.alu_src = 1'b1; end
            CLS_BRANCH: begin c.alu_op = ALU_BRANCH; c.imm_sel = IMM_B; end
            CLS_LOAD:   begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; end
            CLS_STORE:  begin c.alu_src = 1'b1; c.imm_sel = IMM_S; end
            CLS_LUI,
            CLS_AUIPC:  begin c.alu_src = 1'b1; c.imm_sel = IMM_U; end
            CLS_JAL:    c.imm_sel = IMM_J;
            CLS_JALR:   c.alu_src = 1'b1;
            default:    ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Fetch-to-controller opcode handshake (transfer on valid & ready).
interface multicycle_control_if;
    logic       instr_valid_i;
    logic       instr_ready_o;
    logic [6:0] op_i;

    modport master (output instr_valid_i, output op_i, input instr_ready_o);
    modport slave  (input instr_valid_i, input op_i, output instr_ready_o);
endinterface

// File: rtl/ctrl_class_decode.sv
// Combinational opcode classifier: maps a 7-bit opcode to its instruction class.
module ctrl_class_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   op,
    output instr_class_t cls,
    output logic         legal
);

    // Classify the opcode; anything unrecognised is illegal.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cls   = CLS_ILLEGAL;
        legal = 1'b1;
        case (op)
            OPC_OP:     cls = CLS_OP;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_VECTOR: cls = CLS_VECTOR;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main-control sequencer: steps each accepted opcode through
// DECODE/EXEC/MEM/WB (or VEC lanes) and drives the datapath strobes.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int VEC_LANES   = 4,
    parameter int MEM_TIMEOUT = 16,
    localparam int LANE_W     = (VEC_LANES > 1) ? $clog2(VEC_LANES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    multicycle_control_if.slave fetch,
    input  logic              mem_ack_i,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic              MemRd_o,
    output logic              MemWr_o,
    output logic              MemToReg_o,
    output logic [2:0]        immSelect_o,
    output logic              Branch_o,
    output logic              PCWrite_o,
    output logic [LANE_W-1:0] lane_idx_o,
    output logic              busy_o,
    output logic              fault_o,
    output logic [1:0]        fault_code_o
);

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(VEC_LANES - 1);

    state_t            state_q;
    logic [6:0]        op_q;
    logic [LANE_W-1:0] lane_q;
    logic [TO_W-1:0]   to_cnt_q;
    fault_code_t       fault_code_q;
    // A store retires on the ack edge; its PC commit is shown from this flag in
    // the following IDLE cycle so that no output depends on mem_ack_i directly.
    logic              store_retire_q;

    instr_class_t cls;
    logic         legal;
    class_ctrl_t  ctrl;

    ctrl_class_decode u_class_decode (
        .op    (op_q),
        .cls   (cls),
        .legal (legal)
    );

    // Sequencer: state, opcode, lane and timeout registers.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            lane_q         <= '0;
            to_cnt_q       <= '0;
            fault_code_q   <= FAULT_NONE;
            store_retire_q <= 1'b0;
        end else begin
            store_retire_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fetch.instr_valid_i) begin
                        op_q    <= fetch.op_i;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q      <= S_FAULT;
                        fault_code_q <= FAULT_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        CLS_BRANCH: state_q <= S_IDLE;
                        CLS_LOAD,
                        CLS_STORE: begin
                            state_q  <= S_MEM;
                            to_cnt_q <= '0;
                        end
                        CLS_VECTOR: begin
                            state_q <= S_VEC;
                            lane_q  <= '0;
                        end
                        default: state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    // An ack on the final count still completes the access.
                    if (mem_ack_i) begin
                        if (cls == CLS_LOAD) begin
                            state_q <= S_WB;
                        end else begin
                            state_q        <= S_IDLE;
                            store_retire_q <= 1'b1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q      <= S_FAULT;
                        fault_code_q <= FAULT_TIMEOUT;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_WB: state_q <= S_IDLE;
                S_VEC: begin
                    if (lane_q == LANE_LAST) begin
                        state_q <= S_IDLE;
                        lane_q  <= '0;
                    end else begin
                        lane_q <= lane_q + 1'b1;
                    end
                end
                S_FAULT: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode from the state, opcode-class and lane registers only.
    always_comb begin
        ctrl        = class_ctrl(cls);
        ALUOp_o     = 2'b00;
        ALUSrc_o    = 1'b0;
        immSelect_o = 3'd0;
        MemToReg_o  = 1'b0;
        RegWrite_o  = 1'b0;
        MemRd_o     = 1'b0;
        MemWr_o     = 1'b0;
        Branch_o    = 1'b0;
        PCWrite_o   = store_retire_q;
        fault_o     = 1'b0;
        if (state_q inside {S_EXEC, S_MEM, S_WB, S_VEC}) begin
            ALUOp_o     = ctrl.alu_op;
            ALUSrc_o    = ctrl.alu_src;
            immSelect_o = ctrl.imm_sel;
            MemToReg_o  = ctrl.mem_to_reg;
        end
        case (state_q)
            S_EXEC: begin
                if (cls == CLS_BRANCH) begin
                    Branch_o  = 1'b1;
                    PCWrite_o = 1'b1;
                end
            end
            S_MEM: begin
                MemRd_o = (cls == CLS_LOAD);
                MemWr_o = (cls == CLS_STORE);
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                PCWrite_o  = 1'b1;
            end
            S_VEC: begin
                RegWrite_o = 1'b1;
                PCWrite_o  = (lane_q == LANE_LAST);
            end
            S_FAULT: fault_o = 1'b1;
            default: ;
        endcase
    end

    assign fetch.instr_ready_o = (state_q == S_IDLE) && rst_ni;
    assign busy_o              = (state_q != S_IDLE);
    assign lane_idx_o          = lane_q;
    assign fault_code_o        = fault_code_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes the expected
// per-cycle control trace of each opcode, a monitor pops and compares it.
module tb_multicycle_control;

    localparam int VEC_LANES   = 4;
    localparam int MEM_TIMEOUT = 16;

    typedef struct packed {
        logic       busy;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic [2:0] imm_sel;
        logic       branch;
        logic       pc_write;
        logic [1:0] lane;
        logic       fault;
        logic [1:0] fault_code;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        int         ack;
        int         lat;
    } vec_t;

    logic clk;
    logic rst_n;
    logic mem_ack;
    logic [1:0] alu_op;
    logic alu_src, reg_write, mem_rd, mem_wr, mem_to_reg, branch, pc_write;
    logic [2:0] imm_sel;
    logic [1:0] lane_idx;
    logic busy, fault;
    logic [1:0] fault_code;

    int   checks = 0;
    int   errors = 0;
    int   ack_delay = -1;
    int   mem_cycle = 0;
    bit   mon_en = 1'b1;
    logic [1:0] exp_code = 2'b00;
    obs_t exp_q[$];
    vec_t vecs[$];

    multicycle_control_if fif ();

    multicycle_control #(.VEC_LANES(VEC_LANES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fetch        (fif),
        .mem_ack_i    (mem_ack),
        .ALUOp_o      (alu_op),
        .ALUSrc_o     (alu_src),
        .RegWrite_o   (reg_write),
        .MemRd_o      (mem_rd),
        .MemWr_o      (mem_wr),
        .MemToReg_o   (mem_to_reg),
        .immSelect_o  (imm_sel),
        .Branch_o     (branch),
        .PCWrite_o    (pc_write),
        .lane_idx_o   (lane_idx),
        .busy_o       (busy),
        .fault_o      (fault),
        .fault_code_o (fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy       = busy;
        o.alu_op     = alu_op;
        o.alu_src    = alu_src;
        o.reg_write  = reg_write;
        o.mem_rd     = mem_rd;
        o.mem_wr     = mem_wr;
        o.mem_to_reg = mem_to_reg;
        o.imm_sel    = imm_sel;
        o.branch     = branch;
        o.pc_write   = pc_write;
        o.lane       = lane_idx;
        o.fault      = fault;
        o.fault_code = fault_code;
        return o;
    endfunction

    // Expected per-cycle trace from DECODE to retire/fault, hand-tabulated per opcode.
    task automatic push_seq(input logic [6:0] op, input int ack_dly);
        obs_t base, c, e;
        bit   legal;
        int   n_mem;
        base = '0;
        base.busy = 1'b1;
        base.fault_code = exp_code;
        exp_q.push_back(base);
        c = base;
        legal = 1'b1;
        case (op)
            7'b0110011: c.alu_op = 2'b10;
            7'b0010011: begin c.alu_op = 2'b11; c.alu_src = 1'b1; c.imm_sel = 3'd0; end
            7'b1100011: begin c.alu_op = 2'b01; c.imm_sel = 3'd2; end
            7'b0000011: begin c.alu_src = 1'b1; c.imm_sel = 3'd0; c.mem_to_reg = 1'b1; end
            7'b0100011: begin c.alu_src = 1'b1; c.imm_sel = 3'd1; end
            7'b0110111,
            7'b0010111: begin c.alu_src = 1'b1; c.imm_sel = 3'd3; end
            7'b1101111: c.imm_sel = 3'd4;
            7'b1100111: begin c.alu_src = 1'b1; c.imm_sel = 3'd0; end
            7'b1010111: ;
            default:    legal = 1'b0;
        endcase
        if (!legal) begin
            exp_code = 2'b01;
            e = base;
            e.fault = 1'b1;
            e.fault_code = 2'b01;
            exp_q.push_back(e);
        end else if (op == 7'b1100011) begin
            e = c;
            e.branch = 1'b1;
            e.pc_write = 1'b1;
            exp_q.push_back(e);
        end else begin
            exp_q.push_back(c);
            if (op == 7'b0000011 || op == 7'b0100011) begin
                n_mem = (ack_dly < 0) ? MEM_TIMEOUT : ack_dly + 1;
                for (int i = 0; i < n_mem; i++) begin
                    e = c;
                    if (op == 7'b0000011) e.mem_rd = 1'b1;
                    else e.mem_wr = 1'b1;
                    exp_q.push_back(e);
                end
                e = '0;
                if (ack_dly < 0) begin
                    exp_code = 2'b10;
                    e.busy = 1'b1;
                    e.fault = 1'b1;
                    e.fault_code = 2'b10;
                end else if (op == 7'b0000011) begin
                    e = c;
                    e.reg_write = 1'b1;
                    e.pc_write = 1'b1;
                end else begin
                    e.pc_write = 1'b1;
                    e.fault_code = exp_code;
                end
                exp_q.push_back(e);
            end else if (op == 7'b1010111) begin
                for (int i = 0; i < VEC_LANES; i++) begin
                    e = c;
                    e.reg_write = 1'b1;
                    e.lane = 2'(i);
                    e.pc_write = (i == VEC_LANES - 1);
                    exp_q.push_back(e);
                end
            end else begin
                e = c;
                e.reg_write = 1'b1;
                e.pc_write = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Count cycles after the handshake edge until instr_ready_o returns (bounded).
    task automatic wait_ready(input string name, input int exp_lat);
        int lat;
        lat = 1;
        while (!fif.instr_ready_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, 32'(lat), 32'(exp_lat));
    endtask

    task automatic issue(input logic [6:0] op, input int ack_dly, input int exp_lat);
        int t;
        t = 0;
        while (!fif.instr_ready_o && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("ready_before_issue", 32'(fif.instr_ready_o), 32'd1);
        push_seq(op, ack_dly);
        ack_delay = ack_dly;
        fif.op_i = op;
        fif.instr_valid_i = 1'b1;
        @(posedge clk);
        #1;
        fif.instr_valid_i = 1'b0;
        fif.op_i = 7'h00;
        wait_ready($sformatf("latency_op%07b_ack%0d", op, ack_dly), exp_lat);
    endtask

    // Data-memory responder: acks ack_delay cycles into MEM (never if negative).
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (mem_rd || mem_wr)) begin
                mem_ack = (ack_delay >= 0) && (mem_cycle == ack_delay);
                mem_cycle++;
            end else begin
                mem_ack = 1'b0;
                mem_cycle = 0;
            end
        end
    end

    // Monitor: every active-output cycle must match the next expected trace entry.
    always @(negedge clk) begin
        obs_t o;
        obs_t e;
        if (mon_en && rst_n) begin
            o = sample();
            if (o.busy || o.pc_write || o.fault) begin
                if (exp_q.size() == 0) begin
                    check("trace_unexpected", 32'(o), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("trace", 32'(o), 32'(e));
                end
            end
        end
    end

    initial begin
        int pcw_seen;
        rst_n = 1'b0;
        fif.instr_valid_i = 1'b0;
        fif.op_i = 7'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outputs", {fif.instr_ready_o, sample()}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(fif.instr_ready_o), 32'd1);

        vecs.push_back('{7'b0110011, -1, 4});
        vecs.push_back('{7'b0010011, -1, 4});
        vecs.push_back('{7'b0110111, -1, 4});
        vecs.push_back('{7'b0010111, -1, 4});
        vecs.push_back('{7'b1101111, -1, 4});
        vecs.push_back('{7'b1100111, -1, 4});
        vecs.push_back('{7'b1100011, -1, 3});
        vecs.push_back('{7'b0000011,  0, 5});
        vecs.push_back('{7'b0000011,  2, 7});
        vecs.push_back('{7'b0100011,  0, 4});
        vecs.push_back('{7'b0100011, 15, 19});
        vecs.push_back('{7'b0100011, -1, 20});
        vecs.push_back('{7'b1010111, -1, 7});
        vecs.push_back('{7'b0000000, -1, 3});
        vecs.push_back('{7'b0110011, -1, 4});
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].ack, vecs[i].lat);

        // Illegal opcode with valid held high: the follow-on OP waits for IDLE.
        push_seq(7'b1111111, -1);
        push_seq(7'b0110011, -1);
        fif.op_i = 7'b1111111;
        fif.instr_valid_i = 1'b1;
        @(posedge clk);
        #1;
        fif.op_i = 7'b0110011;
        wait_ready("latency_illegal_held", 3);
        @(posedge clk);
        #1;
        fif.instr_valid_i = 1'b0;
        fif.op_i = 7'h00;
        wait_ready("latency_after_held", 4);

        // Reset in the middle of a load: outputs clear at once, nothing retires.
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        ack_delay = -1;
        fif.op_i = 7'b0000011;
        fif.instr_valid_i = 1'b1;
        @(posedge clk);
        #1;
        fif.instr_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_load_memrd", 32'(mem_rd), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {fif.instr_ready_o, sample()}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pcw_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (pc_write) pcw_seen++;
        end
        check("abort_ready", 32'(fif.instr_ready_o), 32'd1);
        check("abort_no_pcwrite", 32'(pcw_seen), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
